alu_serial_rx: RTL and testbench
================================

// Module: alu_serial_rx
// PURPOSE
// - Serial command receiver at the ALU input; sits between the sin line and the ALU core.
// - Deframes 11-bit serial frames and assembles 8 data bytes (B then A, MSB first) plus one CTL byte.
// - Checks frame count, CRC-4 and opcode, then presents either one parallel command {A, B, op} or one error code.
// PARAMETERS
// - DATA_BYTES      8    data frames per packet (B[31:24]..B[7:0], A[31:24]..A[7:0])
// - TIMEOUT_CYCLES  64   idle clocks that abort a partial packet (ALU_RX_TIMEOUT_EN only)
// PORTS
// - clk        in   1   clock, all state on posedge
// - rst_n      in   1   reset, asynchronous, active-low
// - sin        in   1   serial input, idles high; driver changes it on negedge
// - A_out      out  32  operand A, held until next accepted packet
// - B_out      out  32  operand B, held until next accepted packet
// - op_out     out  3   opcode: and=000, or=001, add=100, sub=101
// - out_valid  out  1   1-cycle pulse; A_out/B_out/op_out are valid on it
// - err_valid  out  1   1-cycle pulse; err_flags is valid on it
// - err_flags  out  3   {ERR_DATA, ERR_CRC, ERR_OP}, one-hot, held until next err_valid
// BEHAVIOUR
// - Reset values: all outputs 0; FSM in IDLE; byte counter 0; CRC register 0; partial packet discarded.
// - Framing: 11 bits, MSB first: start=0, type (0=DATA, 1=CTL), payload[7:0], stop=1.
// - Sampling: sin sampled on posedge. The cycle in which IDLE sees sin==0 is bit 0 (start).
// - Frame timing: stop bit is sampled 10 cycles after the start bit.
// - Back-to-back: a start bit in the cycle right after a stop bit must be accepted (no gap required).
// - FSM states:
//   - IDLE -> TYPE on sin==0.
//   - TYPE -> PAYLOAD (bit counter 7..0).
//   - PAYLOAD -> STOP.
//   - STOP -> IDLE.
//   - A stop bit of 0 sets a sticky frame_err for the current packet.
// - DATA frame: payload shifts into a 64-bit {B,A} shift register and byte_cnt increments.
//   - byte_cnt saturates at DATA_BYTES+1; any value other than DATA_BYTES at CTL time is a count error.
// - CRC-4: polynomial x^4+x+1, init 4'b0000, fed serially MSB first.
//   - Message is the 68 bits {B[31:0], A[31:0], 1'b1, op[2:0]}; it must equal calc_crc_4b in alu_pkg.
//   - Data bits are folded in as each byte arrives; the 1'b1 and op bits are folded in at CTL time.
// - CTL frame: payload = {rsvd, op[2:0], crc[3:0]}; rsvd is ignored.
//   - Evaluated in the cycle after its stop bit, with priority:
//     1. byte_cnt!=DATA_BYTES or frame_err   -> err_valid, err_flags=3'b100
//     2. else received crc != computed crc   -> err_valid, err_flags=3'b010
//     3. else op not in {000,001,100,101}    -> err_valid, err_flags=3'b001
//     4. else out_valid; A_out, B_out and op_out load in the same cycle
// - Latency: out_valid/err_valid assert exactly 1 cycle after the CTL stop-bit sample.
// - Never both out_valid and err_valid in the same cycle.
// - After any CTL frame: byte_cnt, CRC and frame_err clear. The next start bit begins a new packet.
// - The evaluation cycle and a new start bit may coincide; both must be handled.
// - rst_n low at any point (mid-frame, mid-packet): immediate return to the reset state.
//   - No pulse is emitted for the aborted packet.
// CONFIGURATION
// - ALU_RX_TIMEOUT_EN defined:
//   - A counter runs while in IDLE with byte_cnt>0.
//   - At TIMEOUT_CYCLES idle clocks: clear byte_cnt, CRC and frame_err; emit err_valid with err_flags=3'b100.
//   - Any start bit clears the counter.
// - ALU_RX_TIMEOUT_EN undefined:
//   - No timeout logic; a partial packet waits indefinitely and completes with the next CTL frame.
// TESTING
// - Good packet: B=32'h2, A=32'h1, op=100, correct crc
//   -> out_valid 1 cycle after CTL stop; A_out=1, B_out=2, op_out=100; err_valid stays 0.
// - Bad CRC: B=32'hFFFF_FFFF, A=32'h8000_0000, op=101, crc+1
//   -> err_valid with err_flags=3'b010; A_out/B_out unchanged.
// - Short packet: 7 DATA frames then CTL (op=000, any crc) -> err_flags=3'b100.
// - Invalid opcode: op=111 with correct crc -> err_flags=3'b001.
// - Back-to-back: two good packets with zero gap -> two out_valid pulses, each with correct data.
// - Reset and timeout:
//   - rst_n low after 4 DATA frames, then a full good packet -> exactly one out_valid, with the new data.
//   - With ALU_RX_TIMEOUT_EN: 3 DATA frames, then sin held high for 64 clocks -> err_flags=3'b100.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// CRC-4 (x^4+x+1) helpers used by the serial receiver.
package alu_pkg;

  function automatic logic [3:0] crc4_step(
    input logic [3:0] c,
    input logic       b
  );
    logic fb;
    fb = c[3] ^ b;
    return {c[2:0], 1'b0} ^ {2'b00, fb, fb};
  endfunction

  function automatic logic [3:0] calc_crc_4b(
    input logic [67:0] msg
  );
    logic [3:0] c;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      c = crc4_step(c, msg[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_serial_rx_if.sv
// Serial line in, parallel command / error code out.
// master drives sin, slave is the receiver.
interface alu_serial_rx_if;
  logic        sin;
  logic [31:0] A_out;
  logic [31:0] B_out;
  logic [2:0]  op_out;
  logic        out_valid;
  logic        err_valid;
  logic [2:0]  err_flags;

  modport master (
    output sin,
    input  A_out, B_out, op_out,
    input  out_valid, err_valid, err_flags
  );

  modport slave (
    input  sin,
    output A_out, B_out, op_out,
    output out_valid, err_valid, err_flags
  );
endinterface

// File: rtl/alu_serial_rx.sv
// Serial command receiver: deframes, checks count/CRC/op.
// Optional idle timeout: define ALU_RX_TIMEOUT_EN.
module alu_serial_rx
  import alu_pkg::*;
#(
  parameter int DATA_BYTES = 8
`ifdef ALU_RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input logic            clk,
  input logic            rst_n,
  alu_serial_rx_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TYPE    = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] STOP    = 2'd3;

  localparam int CW = $clog2(DATA_BYTES + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_BYTES);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_BYTES + 1);

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic          is_ctl;
  logic [7:0]    pay;
  logic [63:0]   sr;
  logic [CW-1:0] byte_cnt;
  logic [3:0]    crc;
  logic          frame_err;
  logic [3:0]    crc_data;
  logic [3:0]    crc_ctl;

`ifdef ALU_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;
`endif

  // CRC after folding a data byte, and after the {1, op} tail
  always_comb begin
    crc_data = crc;
    for (int i = 7; i >= 0; i--) begin
      crc_data = crc4_step(crc_data, pay[i]);
    end
    crc_ctl = crc4_step(crc, 1'b1);
    for (int i = 2; i >= 0; i--) begin
      crc_ctl = crc4_step(crc_ctl, pay[4+i]);
    end
  end

  // Frame deserialiser: start, type, 8 payload bits, stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      is_ctl  <= 1'b0;
      pay     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.sin) state <= TYPE;
        end
        TYPE: begin
          is_ctl  <= bus.sin;
          bit_cnt <= 3'd7;
          state   <= PAYLOAD;
        end
        PAYLOAD: begin
          pay <= {pay[6:0], bus.sin};
          if (bit_cnt == 3'd0) state <= STOP;
          else bit_cnt <= bit_cnt - 3'd1;
        end
        STOP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Packet assembly, CTL evaluation and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr            <= '0;
      byte_cnt      <= '0;
      crc           <= '0;
      frame_err     <= 1'b0;
      bus.A_out     <= '0;
      bus.B_out     <= '0;
      bus.op_out    <= '0;
      bus.out_valid <= 1'b0;
      bus.err_valid <= 1'b0;
      bus.err_flags <= '0;
`ifdef ALU_RX_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      bus.out_valid <= 1'b0;
      bus.err_valid <= 1'b0;
      if (state == STOP) begin
        if (!is_ctl) begin
          sr  <= {sr[55:0], pay};
          crc <= crc_data;
          if (byte_cnt != CNT_SAT) byte_cnt <= byte_cnt + 1'b1;
          if (!bus.sin) frame_err <= 1'b1;
        end else begin
          byte_cnt  <= '0;
          crc       <= '0;
          frame_err <= 1'b0;
          if (byte_cnt != CNT_FULL || frame_err || !bus.sin) begin
            bus.err_valid <= 1'b1;
            bus.err_flags <= 3'b100;
          end else if (pay[3:0] != crc_ctl) begin
            bus.err_valid <= 1'b1;
            bus.err_flags <= 3'b010;
          end else if (pay[5]) begin
            bus.err_valid <= 1'b1;
            bus.err_flags <= 3'b001;
          end else begin
            bus.out_valid <= 1'b1;
            bus.A_out     <= sr[31:0];
            bus.B_out     <= sr[63:32];
            bus.op_out    <= pay[6:4];
          end
        end
      end
`ifdef ALU_RX_TIMEOUT_EN
      if (state == IDLE && byte_cnt != '0) begin
        if (!bus.sin) begin
          to_cnt <= '0;
        end else if (to_cnt == TO_LAST) begin
          to_cnt        <= '0;
          byte_cnt      <= '0;
          crc           <= '0;
          frame_err     <= 1'b0;
          bus.err_valid <= 1'b1;
          bus.err_flags <= 3'b100;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Bench for alu_serial_rx: scoreboard of expected pulses.
// Timeout case runs only with ALU_RX_TIMEOUT_EN.
module tb_alu_serial_rx;

  typedef struct {
    bit          is_err;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  flags;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  logic [31:0] m_a, m_b;
  logic [2:0]  m_op, m_flags;

  alu_serial_rx_if bus();

  alu_serial_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] crc_ref(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'h0};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input bit typ, input logic [7:0] pay,
                            input bit stop, output int sc);
    logic [10:0] f;
    f = {1'b0, typ, pay, stop};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      bus.sin = f[i];
    end
    sc = cyc;
  endtask

  task automatic push(input bit is_err, input int c);
    exp_t e;
    e.is_err = is_err;
    e.a      = m_a;
    e.b      = m_b;
    e.op     = m_op;
    e.flags  = m_flags;
    e.cyc    = c;
    sb.push_back(e);
  endtask

  task automatic send_pkt(input logic [31:0] b, input logic [31:0] a,
                          input logic [2:0] op, input logic [3:0] adj,
                          input int nbytes, input int bad_idx);
    logic [63:0] d;
    logic [3:0]  c;
    logic [2:0]  fl;
    int          sc;
    d = {b, a};
    c = crc_ref({b, a, 1'b1, op}) + adj;
    for (int i = 0; i < nbytes; i++) begin
      send_frame(1'b0, d[63-8*i -: 8], i != bad_idx, sc);
    end
    if (nbytes != 8 || bad_idx >= 0) fl = 3'b100;
    else if (adj != 4'd0) fl = 3'b010;
    else if (op[1]) fl = 3'b001;
    else fl = 3'b000;
    send_frame(1'b1, {1'b0, op, c}, 1'b1, sc);
    if (fl == 3'b000) begin
      m_a = a; m_b = b; m_op = op;
    end else begin
      m_flags = fl;
    end
    push(fl != 3'b000, sc + 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_A"}, bus.A_out, 0);
    check({tag, "_B"}, bus.B_out, 0);
    check({tag, "_op"}, bus.op_out, 0);
    check({tag, "_ov"}, bus.out_valid, 0);
    check({tag, "_ev"}, bus.err_valid, 0);
    check({tag, "_fl"}, bus.err_flags, 0);
  endtask

  // Pop and compare on every pulse
  always @(negedge clk) begin
    if (rst_n && (bus.out_valid || bus.err_valid)) begin
      exp_t e;
      check("both", bus.out_valid & bus.err_valid, 0);
      if (sb.size() == 0) begin
        check("spurious", bus.out_valid | bus.err_valid, 0);
      end else begin
        e = sb.pop_front();
        check("out_valid", bus.out_valid, !e.is_err);
        check("err_valid", bus.err_valid, e.is_err);
        check("A_out", bus.A_out, e.a);
        check("B_out", bus.B_out, e.b);
        check("op_out", bus.op_out, e.op);
        check("err_flags", bus.err_flags, e.flags);
        check("latency", cyc, e.cyc);
      end
    end
  end

  logic [31:0] ra, rb;
  logic [2:0]  ops [4];
  int          sc;

  initial begin
    ops[0] = 3'b000; ops[1] = 3'b001;
    ops[2] = 3'b100; ops[3] = 3'b101;
    bus.sin = 1'b1;
    m_a = '0; m_b = '0; m_op = '0; m_flags = '0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_pkt(32'h2, 32'h1, 3'b100, 4'd0, 8, -1);
    send_pkt(32'hFFFF_FFFF, 32'h8000_0000, 3'b101, 4'd1, 8, -1);
    send_pkt(32'h1111_2222, 32'h3333_4444, 3'b000, 4'd0, 7, -1);
    send_pkt(32'h1234_5678, 32'h9ABC_DEF0, 3'b111, 4'd0, 8, -1);
    send_pkt(32'hCAFE_F00D, 32'h0BAD_BEEF, 3'b001, 4'd0, 8, 3);
    repeat (3) @(negedge clk);

    send_pkt(32'hA5A5_0001, 32'h5A5A_0002, 3'b000, 4'd0, 8, -1);
    send_pkt(32'h0000_00FF, 32'hFF00_0000, 3'b101, 4'd0, 8, -1);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      send_frame(1'b0, 8'($urandom), 1'b1, sc);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    m_a = '0; m_b = '0; m_op = '0; m_flags = '0;
    @(negedge clk);
    check_zero("mid_rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_pkt(32'hDEAD_0004, 32'hBEEF_0003, 3'b001, 4'd0, 8, -1);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      send_pkt(rb, ra, ops[$urandom_range(3)], 4'd0, 8, -1);
    end
    repeat (3) @(negedge clk);

`ifdef ALU_RX_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      send_frame(1'b0, 8'(8'h10 + i), 1'b1, sc);
    end
    m_flags = 3'b100;
    push(1'b1, sc + 65);
    repeat (70) @(negedge clk);
    send_pkt(32'h0000_0077, 32'h0000_0066, 3'b100, 4'd0, 8, -1);
`endif

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
